bitwise_arbiter: RTL and testbench
==================================

BITWISE_ARBITER -- requirements
Module: bitwise_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH  7  operand/result width
  LAT    1  bitwise unit latency, clock edges from operands driven to q valid; legal range 1..7
REQ-002 Ports SHALL be, one per line:
  clk         in   1      single clock, rising edge
  rst_n       in   1      synchronous, active-low reset
  req0_valid  in   1      requester 0 has an op
  req0_ready  out  1      requester 0 op accepted this cycle
  req0_a      in   WIDTH  requester 0 operand a
  req0_b      in   WIDTH  requester 0 operand b
  req0_op     in   2      requester 0 opcode
  req1_valid  in   1      requester 1 has an op
  req1_ready  out  1      requester 1 op accepted this cycle
  req1_a      in   WIDTH  requester 1 operand a
  req1_b      in   WIDTH  requester 1 operand b
  req1_op     in   2      requester 1 opcode
  alu_a       out  WIDTH  operand a to shared bitwise unit
  alu_b       out  WIDTH  operand b to shared bitwise unit
  alu_op      out  2      opcode to shared bitwise unit
  alu_q       in   WIDTH  result from shared bitwise unit
  rsp_valid   out  1      result available
  rsp_ready   in   1      consumer takes result
  rsp_id      out  1      requester owning rsp_q
  rsp_q       out  WIDTH  captured result
  busy        out  1      high whenever state is not IDLE
REQ-003 Clock and reset SHALL be one clock; reset synchronous and active-low.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-005 In IDLE, reqN_ready SHALL be combinationally high only for the granted requester, and only while its reqN_valid is high; at most one ready SHALL be high in any cycle.
REQ-006 Accept SHALL occur on an edge where reqN_valid and reqN_ready are both high. On that edge the block SHALL:
  - register reqN_a/b/op into alu_a/alu_b/alu_op;
  - register N into rsp_id;
  - clear the wait counter;
  - go to WAIT.
REQ-007 alu_a/alu_b/alu_op SHALL hold their values until the next accept.
REQ-008 In WAIT the counter SHALL increment each edge. On the edge where counter==LAT, alu_q SHALL be registered into rsp_q and the FSM SHALL go to RESP.
REQ-009 rsp_valid SHALL be high exactly while in RESP; its first high cycle follows the (LAT+1)th rising edge after the accept edge.
REQ-010 In RESP, rsp_valid&rsp_ready SHALL return the FSM to IDLE. No accept SHALL occur in that same cycle; the earliest next accept is the following cycle.
REQ-011 rsp_q and rsp_id SHALL remain stable while rsp_valid is high and rsp_ready is low.
REQ-012 rsp_ready SHALL be ignored outside RESP; reqN_valid SHALL be ignored outside IDLE (both readys low).
REQ-013 A requester may drop valid before grant; no state SHALL be retained for it.
REQ-014 If only one requester is valid in IDLE, it SHALL be granted regardless of arbitration history.

Reset
REQ-015 While rst_n is low at a rising edge, all of the following SHALL hold after that edge:
  - state = IDLE, counter = 0;
  - alu_a/alu_b/alu_op = 0;
  - rsp_valid = 0, rsp_id = 0, rsp_q = 0;
  - last_grant = 1;
  - busy = 0; both readys low.
REQ-016 Reset asserted in WAIT or RESP SHALL abandon the operation; no response SHALL be produced for it.

Configuration
REQ-017 Macro BWARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-018 With BWARB_ROUND_ROBIN_EN defined: when both requesters are valid, the one not equal to last_grant SHALL win; last_grant SHALL update on every accept.
REQ-019 Without BWARB_ROUND_ROBIN_EN: requester 0 SHALL always win ties, and last_grant SHALL be unused.

Verification
The bench SHALL model the bitwise unit as a registered unit with LAT=1: q <= a&b for op 00, a|b for 01, a^b for 10, ~a for 11.
REQ-020 Single op: req0 a=7'h55, b=7'h0F, op=00 -> rsp_valid two edges after accept; rsp_q=7'h05, rsp_id=0.
REQ-021 Tie, round-robin enabled: both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1.
REQ-022 Tie, macro undefined: same stimulus as REQ-021 -> every grant goes to 0; req1_ready never high.
REQ-023 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_q, rsp_id stable throughout; busy=1 throughout; no accept until 1 cycle after handshake.
REQ-024 Reset mid-op: assert rst_n=0 in WAIT -> no rsp_valid; all outputs 0; busy=0.
REQ-025 Single requester: req1 only, a=7'h7F, b=0, op=10 -> rsp_q=7'h7F, rsp_id=1.

Source files
------------

// File: rtl/bitwise_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_arbiter
// Description : Two-requester arbiter in front of one shared bitwise unit.
//               The winner's operands are registered towards the unit, the
//               result is captured LAT+1 edges after the accept and held
//               until the consumer takes it.
//               Macro BWARB_ROUND_ROBIN_EN: defined -> round-robin on ties,
//               undefined -> requester 0 always wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_arbiter #(
    parameter int WIDTH = 7,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_q,
    output logic             busy
);

    // Counter wide enough for the largest legal latency (7).
    localparam int               c_cnt_w = 3;
    localparam logic [c_cnt_w-1:0] c_lat = c_cnt_w'(LAT);

    // Reject latencies the counter cannot represent.
    generate
        if (LAT < 1 || LAT > 7) begin : g_lat_check
            $error("bitwise_arbiter: LAT must be in 1..7");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     alu_a_q, alu_a_d;
    logic [WIDTH-1:0]     alu_b_q, alu_b_d;
    logic [1:0]           alu_op_q, alu_op_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 w_tie_pick1;
    logic                 w_pick1;
    logic                 w_idle;
    logic                 w_accept;

`ifdef BWARB_ROUND_ROBIN_EN
    logic                 last_grant_q, last_grant_d;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        w_tie_pick1 = (last_grant_q == 1'b0);
    end

    // Remember the most recent winner; updated on every accept.
    always_comb begin
        last_grant_d = last_grant_q;
        if (w_accept) begin
            last_grant_d = w_pick1;
        end
    end

    // Last-grant register; reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: requester 0 wins every tie.
    always_comb begin
        w_tie_pick1 = 1'b0;
    end
`endif

    // Choose which requester would be granted if the block were idle.
    always_comb begin
        w_pick1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_pick1 = w_tie_pick1;
        end else if (req1_valid) begin
            w_pick1 = 1'b1;
        end
    end

    // Readys only while idle and out of reset; pick makes them exclusive.
    always_comb begin
        w_idle     = (state_q == ST_IDLE) && rst_n;
        req0_ready = w_idle && req0_valid && !w_pick1;
        req1_ready = w_idle && req1_valid &&  w_pick1;
        w_accept   = req0_ready || req1_ready;
    end

    // Next-state and datapath update for the IDLE/WAIT/RESP sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        rsp_id_d = rsp_id_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_pick1) begin
                        alu_a_d  = req1_a;
                        alu_b_d  = req1_b;
                        alu_op_d = req1_op;
                    end else begin
                        alu_a_d  = req0_a;
                        alu_b_d  = req0_b;
                        alu_op_d = req0_op;
                    end
                    rsp_id_d = w_pick1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The unit's result is valid once the counter reaches LAT.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_lat) begin
                    result_d = alu_q;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                // Returning to IDLE here means the next accept is a cycle later.
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rsp_id_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            rsp_id_q <= rsp_id_d;
            result_q <= result_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = result_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bitwise_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_arbiter
// Description : Scoreboard bench for bitwise_arbiter with a registered
//               LAT=1 bitwise unit model. Honours BWARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_arbiter;

    localparam int WIDTH = 7;
    localparam int LAT   = 1;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_q;
    logic [1:0]       alu_op;
    logic             rsp_valid, rsp_ready, rsp_id, busy;
    logic [WIDTH-1:0] rsp_q;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] q;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
`ifdef BWARB_ROUND_ROBIN_EN
    int   model_last = 1;
`endif

    bitwise_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_q(alu_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_q(rsp_q), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] bitop(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Shared bitwise unit: one register stage.
    always @(posedge clk) alu_q <= bitop(alu_a, alu_b, alu_op);

    // Which requester the rules say wins: -1 none, else 0/1.
    function automatic int model_winner(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef BWARB_ROUND_ROBIN_EN
            return (model_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic junk_inputs();
        req0_valid = 1'($urandom);
        req1_valid = 1'($urandom);
        req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_op = 2'($urandom);
        req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_op = 2'($urandom);
    endtask

    // One transaction from an idle block; bp<0 gives random backpressure,
    // otherwise rsp_ready is held low for bp RESP cycles.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0, input logic [1:0] op0,
                           input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input logic [1:0] op1,
                           input int bp);
        int   w;
        int   cyc;
        bit   done;
        exp_t e;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = 1'($urandom);
        w = model_winner(v0, v1);
        #1;
        check("busy_idle", busy, 0);
        check("req0_ready", req0_ready, (w == 0));
        check("req1_ready", req1_ready, (w == 1));
        if (w < 0) return;
        e.id = (w == 1);
        e.q  = (w == 1) ? bitop(a1, b1, op1) : bitop(a0, b0, op0);
        exp_q.push_back(e);
        @(posedge clk);
`ifdef BWARB_ROUND_ROBIN_EN
        model_last = w;
`endif
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            junk_inputs();
            rsp_ready = 1'($urandom);
            #1;
            if (k == 0) begin
                check("alu_a", alu_a, (w == 1) ? a1 : a0);
                check("alu_b", alu_b, (w == 1) ? b1 : b0);
                check("alu_op", alu_op, (w == 1) ? op1 : op0);
            end
            check("rsp_valid_early", rsp_valid, 0);
            check("busy_wait", busy, 1);
            @(posedge clk);
        end
        cyc  = 0;
        done = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            junk_inputs();
            rsp_ready = (bp < 0) ? ($urandom_range(0, 2) != 0) : (cyc >= bp);
            #1;
            check("rsp_valid_resp", rsp_valid, 1);
            check("busy_resp", busy, 1);
            done = rsp_ready;
            @(posedge clk);
            cyc++;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL resp_timeout: got no handshake expected handshake within 64 cycles");
        end
    endtask

    // Reset while the operation is in WAIT: it must vanish without a response.
    task automatic reset_mid_op();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 7'h3C; req0_b = 7'h33; req0_op = 2'b01;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("busy_before_rst", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_q", rsp_q, 0);
        check("rst_busy", busy, 0);
        check("rst_readys", {req0_ready, req1_ready}, 0);
        rst_n = 1'b1;
`ifdef BWARB_ROUND_ROBIN_EN
        model_last = 1;
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("no_rsp_after_rst", rsp_valid, 0);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stability.
    initial begin : monitor
        logic             pv, pr, pid;
        logic [WIDTH-1:0] pq;
        exp_t             e;
        pv = 0; pr = 0; pid = 0; pq = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n === 1'b1) begin
                if (req0_ready && req1_ready) begin
                    n_cmp++; n_err++;
                    $display("FAIL ready_excl: got both readys high expected at most one");
                end
                if (busy && (req0_ready || req1_ready)) begin
                    n_cmp++; n_err++;
                    $display("FAIL ready_busy: got ready high expected low while busy");
                end
                if (rsp_valid && pv && !pr) begin
                    check("hold_rsp_q", rsp_q, pq);
                    check("hold_rsp_id", rsp_id, pid);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL rsp_unexpected: got id %0d q %0h expected no response", rsp_id, rsp_q);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_q", rsp_q, e.q);
                    end
                end
                pv = rsp_valid; pr = rsp_ready; pq = rsp_q; pid = rsp_id;
            end else begin
                pv = 0; pr = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int bp;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("init_busy", busy, 0);
        check("init_rsp_valid", rsp_valid, 0);
        check("init_rsp_q", rsp_q, 0);
        check("init_rsp_id", rsp_id, 0);
        check("init_alu", {alu_a, alu_b, alu_op}, 0);
        check("init_readys", {req0_ready, req1_ready}, 0);
        rst_n = 1'b1;

        // Single op on requester 0: AND.
        run_txn(1, 0, 7'h55, 7'h0F, 2'b00, 7'h00, 7'h00, 2'b00, 0);
        // Single requester 1: XOR.
        run_txn(0, 1, 7'h00, 7'h00, 2'b00, 7'h7F, 7'h00, 2'b10, 0);
        // Ties back to back.
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 7'h12 + 7'(i), 7'h6A, 2'(i), 7'h21, 7'h44 + 7'(i), 2'(3 - i), 0);
        // Backpressure for 5 RESP cycles.
        run_txn(1, 1, 7'h5A, 7'h3C, 2'b01, 7'h0F, 7'h70, 2'b11, 5);
        // Abandon an operation with reset.
        reset_mid_op();
        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_txn(1'($urandom), 1'($urandom),
                    WIDTH'($urandom), WIDTH'($urandom), 2'($urandom),
                    WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), bp);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
